// File: rtl/max_unpool_pkg.sv
//==============================================================================
// Module      : max_unpool_pkg
// Description : Shared constants, state encoding and helpers for the 2x2
//               max-unpooling stage. Honours MAX_UNPOOL_NN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package max_unpool_pkg;

    localparam logic [1:0] IDX_TL = 2'd0;
    localparam logic [1:0] IDX_TR = 2'd1;
    localparam logic [1:0] IDX_BL = 2'd2;
    localparam logic [1:0] IDX_BR = 2'd3;

    localparam logic [0:0] ST_TOP = 1'b0;
    localparam logic [0:0] ST_BOT = 1'b1;

    typedef enum logic [0:0] {TOP = ST_TOP, BOT = ST_BOT} state_t;

    // Line-buffer entry is {idx, value}; nearest-neighbour mode keeps only the value.
    function automatic int buf_entry_w(input int data_w);
`ifdef MAX_UNPOOL_NN_EN
        return data_w;
`else
        return data_w + 2;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/unpool_line_buf.sv
//==============================================================================
// Module      : unpool_line_buf
// Description : One-write/one-read line buffer with synchronous read, holding
//               the pooled row for replay on the bottom output row.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module unpool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 10,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/max_unpool_2x2.sv
//==============================================================================
// Module      : max_unpool_2x2
// Description : Streaming 2x2 max-unpooling; places each pooled value at its
//               argmax slot. Define MAX_UNPOOL_NN_EN for nearest-neighbour fill.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module max_unpool_2x2
    import max_unpool_pkg::*;
#(
    parameter int In_d_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [In_d_W-1:0] s_data,
    input  logic [1:0]        s_idx,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [In_d_W-1:0] m_data,
    output logic              m_eol,
    output logic              m_eof
);

    localparam int c_COLS = IMG_W / 2;
    localparam int c_ROWS = IMG_H / 2;
    localparam int c_CW   = (c_COLS > 1) ? $clog2(c_COLS) : 1;
    localparam int c_RW   = (c_ROWS > 1) ? $clog2(c_ROWS) : 1;
    localparam int c_BW   = buf_entry_w(In_d_W);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(c_COLS - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(c_ROWS - 1);

    logic [0:0]        r_state;
    logic              r_px;
    logic [c_CW-1:0]   r_col;
    logic [c_RW-1:0]   r_row;
    logic              r_in_en;
    logic [c_BW-1:0]   r_hold;

    logic              w_out_free;
    logic              w_accept;
    logic              w_adv;
    logic              w_col_last;
    logic [c_CW-1:0]   w_col_next;
    logic [c_BW-1:0]   w_wr_entry;
    logic [c_BW-1:0]   w_rd_entry;
    logic [c_BW-1:0]   w_entry;
    logic [In_d_W-1:0] w_val;

    assign w_out_free = !m_valid || m_ready;
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_col_next = w_col_last ? '0 : r_col + 1'b1;

    // r_in_en keeps s_ready low while reset is asserted.
    assign s_ready  = r_in_en && w_out_free && !r_px && (r_state == ST_TOP);
    assign w_accept = s_valid && s_ready;
    assign w_adv    = ((r_state == ST_TOP) && !r_px) ? w_accept : w_out_free;

`ifdef MAX_UNPOOL_NN_EN
    assign w_wr_entry = s_data;
`else
    assign w_wr_entry = {s_idx, s_data};
`endif

    always_comb begin
        w_entry = w_wr_entry;
        if (r_state == ST_BOT) begin
            w_entry = w_rd_entry;
        end else if (r_px) begin
            w_entry = r_hold;
        end
    end

`ifdef MAX_UNPOOL_NN_EN
    assign w_val = w_entry;
`else
    logic [1:0] w_slot;

    always_comb begin
        unique case ({(r_state == ST_BOT), r_px})
            2'b00:   w_slot = IDX_TL;
            2'b01:   w_slot = IDX_TR;
            2'b10:   w_slot = IDX_BL;
            default: w_slot = IDX_BR;
        endcase
    end

    assign w_val = (w_entry[c_BW-1 -: 2] == w_slot) ? w_entry[In_d_W-1:0] : '0;
`endif

    // Reading the next column on every second pixel keeps the bottom row bubble-free.
    unpool_line_buf #(
        .DEPTH (c_COLS),
        .WIDTH (c_BW),
        .AW    (c_CW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (w_accept),
        .wr_addr (r_col),
        .wr_data (w_wr_entry),
        .rd_en   (w_out_free && r_px),
        .rd_addr (w_col_next),
        .rd_data (w_rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TOP;
            r_px    <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_in_en <= 1'b0;
            r_hold  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
            if (w_accept) begin
                r_hold <= w_wr_entry;
            end
            if (w_out_free) begin
                m_valid <= w_adv;
                if (w_adv) begin
                    m_data <= w_val;
                    m_eol  <= r_px && w_col_last;
                    m_eof  <= r_px && w_col_last && (r_state == ST_BOT) && (r_row == c_ROW_LAST);
                    r_px   <= !r_px;
                    if (r_px) begin
                        r_col <= w_col_next;
                        if (w_col_last) begin
                            r_state <= (r_state == ST_TOP) ? ST_BOT : ST_TOP;
                            if (r_state == ST_BOT) begin
                                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_max_unpool_2x2.sv
//==============================================================================
// Module      : tb_max_unpool_2x2
// Description : Self-checking bench for max_unpool_2x2 against a frame-level
//               reference model (honours MAX_UNPOOL_NN_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_max_unpool_2x2;

    localparam int DW    = 8;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int NPIX  = W * H;
    localparam int NPOOL = NPIX / 4;
`ifdef MAX_UNPOOL_NN_EN
    localparam bit NN = 1'b1;
`else
    localparam bit NN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [1:0]    s_idx = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_eol;
    logic          m_eof;

    always #5 clk = ~clk;

    max_unpool_2x2 #(.In_d_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_idx   (s_idx),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_eol   (m_eol),
        .m_eof   (m_eof)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] in_val[$];
    logic [1:0]    in_idx[$];
    logic [DW-1:0] exp_data[$];
    logic          exp_eol[$];
    logic          exp_eof[$];
    logic [DW-1:0] got_data[$];
    logic          got_eol[$];
    logic          got_eof[$];
    int            proto_err;
    int            first_acc;
    int            first_val;
    int            last_xfer;

    task automatic clear_queues();
        in_val.delete(); in_idx.delete();
        exp_data.delete(); exp_eol.delete(); exp_eof.delete();
        got_data.delete(); got_eol.delete(); got_eof.delete();
    endtask

    // Reference: build the full-resolution image from the pooled frame, then scan it row-major.
    task automatic push_frame(input int mode);
        logic [DW-1:0] v[NPOOL];
        logic [1:0]    k[NPOOL];
        for (int i = 0; i < NPOOL; i++) begin
            case (mode)
                1:       begin v[i] = DW'(i + 1);    k[i] = 2'd1;            end
                2:       begin v[i] = DW'(200);      k[i] = 2'd2;            end
                default: begin v[i] = DW'($urandom); k[i] = 2'($urandom);    end
            endcase
            in_val.push_back(v[i]);
            in_idx.push_back(k[i]);
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int p;
                int slot;
                p    = (y / 2) * (W / 2) + (x / 2);
                slot = (y % 2) * 2 + (x % 2);
                exp_data.push_back((NN || int'(k[p]) == slot) ? v[p] : '0);
                exp_eol.push_back(x == W - 1);
                exp_eof.push_back(x == W - 1 && y == H - 1);
            end
        end
    endtask

    // Drives inputs and collects output transfers; all sampling happens 1 ns after the falling edge.
    task automatic run_stream(input int ready_pct, input int gap, input int target, input int max_cyc);
        logic          prev_stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic          pe = 1'b0;
        logic          pf = 1'b0;
        proto_err = 0; first_acc = -1; first_val = -1; last_xfer = -1;
        for (int c = 0; c < max_cyc && got_data.size() < target; c++) begin
            int  pos;
            logic exp_sr;
            @(negedge clk);
            m_ready = ($urandom_range(99) < ready_pct);
            s_valid = (in_val.size() > 0) && (c % gap == 0);
            s_data  = s_valid ? in_val[0] : DW'($urandom);
            s_idx   = s_valid ? in_idx[0] : 2'($urandom);
            #1;
            if (prev_stall && (!m_valid || m_data !== pd || m_eol !== pe || m_eof !== pf))
                proto_err++;
            pos    = (got_data.size() + int'(m_valid)) % NPIX;
            exp_sr = (!m_valid || m_ready) && ((pos / W) % 2 == 0) && ((pos % W) % 2 == 0);
            if (s_ready !== exp_sr)
                proto_err++;
            if (m_valid && first_val < 0) first_val = c;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data); got_eol.push_back(m_eol); got_eof.push_back(m_eof);
                last_xfer = c;
            end
            if (s_valid && s_ready) begin
                if (first_acc < 0) first_acc = c;
                void'(in_val.pop_front());
                void'(in_idx.pop_front());
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data; pe = m_eol; pf = m_eof;
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b expected 0", m_valid); else n_pass++;
        n_checks++; if (m_data !== '0)    $display("FAIL reset_m_data: got %0d expected 0", m_data);   else n_pass++;
        n_checks++; if (m_eol !== 1'b0)   $display("FAIL reset_m_eol: got %0b expected 0", m_eol);     else n_pass++;
        n_checks++; if (m_eof !== 1'b0)   $display("FAIL reset_m_eof: got %0b expected 0", m_eof);     else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %0b expected 0", s_ready); else n_pass++;
        s_valid = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idx_pattern();
        clear_queues();
        push_frame(1);
        run_stream(100, 1, NPIX, 400);
        n_checks++;
        if (got_data.size() != NPIX) $display("FAIL idx_count: got %0d expected %0d", got_data.size(), NPIX); else n_pass++;
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
                $display("FAIL idx_pix%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i,
                         got_data[i], got_eol[i], got_eof[i], exp_data[i], exp_eol[i], exp_eof[i]);
            else n_pass++;
        end
        n_checks++;
        if (first_val - first_acc != 1) $display("FAIL latency: got %0d expected 1", first_val - first_acc); else n_pass++;
        n_checks++;
        if (last_xfer - first_val != NPIX - 1) $display("FAIL throughput: got %0d expected %0d", last_xfer - first_val, NPIX - 1); else n_pass++;
        n_checks++;
        if (proto_err != 0) $display("FAIL idx_protocol: got %0d expected 0", proto_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_queues();
        for (int f = 0; f < 3; f++) push_frame(0);
        run_stream(50, 1, 3 * NPIX, 5000);
        n_checks++;
        if (got_data.size() != 3 * NPIX) $display("FAIL b2b_count: got %0d expected %0d", got_data.size(), 3 * NPIX); else n_pass++;
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
                $display("FAIL b2b_pix%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i,
                         got_data[i], got_eol[i], got_eof[i], exp_data[i], exp_eol[i], exp_eof[i]);
            else n_pass++;
        end
        n_checks++;
        if (proto_err != 0) $display("FAIL b2b_protocol: got %0d expected 0", proto_err); else n_pass++;
    endtask

    task automatic test_gaps();
        clear_queues();
        push_frame(2);
        run_stream(100, 5, NPIX, 2000);
        n_checks++;
        if (got_data.size() != NPIX) $display("FAIL gap_count: got %0d expected %0d", got_data.size(), NPIX); else n_pass++;
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
                $display("FAIL gap_pix%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i,
                         got_data[i], got_eol[i], got_eof[i], exp_data[i], exp_eol[i], exp_eof[i]);
            else n_pass++;
        end
        n_checks++;
        if (proto_err != 0) $display("FAIL gap_protocol: got %0d expected 0", proto_err); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        push_frame(0);
        // Stop partway through the bottom output row of the second pooled row.
        run_stream(100, 1, 3 * W + W / 2, 400);
        m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_eol, m_eof, s_ready} !== 4'b0000 || m_data !== '0)
            $display("FAIL midrst_outputs: got v=%0b d=%0d eol=%0b eof=%0b rdy=%0b expected all 0",
                     m_valid, m_data, m_eol, m_eof, s_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_queues();
        push_frame(0);
        run_stream(70, 1, NPIX, 2000);
        n_checks++;
        if (got_data.size() != NPIX) $display("FAIL midrst_count: got %0d expected %0d", got_data.size(), NPIX); else n_pass++;
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
                $display("FAIL midrst_pix%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i,
                         got_data[i], got_eol[i], got_eof[i], exp_data[i], exp_eol[i], exp_eof[i]);
            else n_pass++;
        end
        n_checks++;
        if (proto_err != 0) $display("FAIL midrst_protocol: got %0d expected 0", proto_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idx_pattern();
        test_back_to_back();
        test_gaps();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
